// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key codes, FSM state and
// per-frame scan result encodings, plus the row/column to key-code map.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'b1010;
  localparam logic [3:0] KEY_HASH = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } key_state_e;

  typedef enum logic [1:0] {
    FRAME_EMPTY  = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_kind_e;

  // Rows 0-2 carry digits 1-9; the bottom row is star, 0, hash.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] row4;
    logic [3:0] col4;
    row4 = {2'b00, row};
    col4 = {2'b00, col};
    if (row == 2'd3) begin
      case (col)
        2'd0:    key_map = KEY_STAR;
        2'd1:    key_map = KEY_0;
        default: key_map = KEY_HASH;
      endcase
    end else begin
      key_map = row4 * 4'd3 + col4 + 4'd1;
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key delivery channel between the scanner (master) and the credential FSM
// (slave): one 4-bit code per valid/ready handshake plus an overrun pulse.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_frame_collect.sv
// Row driver and column accumulator: walks the four rows, samples the columns
// at the end of each row slot and classifies every 4-row frame.
module keypad_frame_collect
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row_o,
  input  logic [2:0]  col_i,
  output logic        frame_done,
  output frame_kind_e frame_kind,
  output logic [3:0]  frame_code
);

  localparam int              DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [1:0]    row_reg;
  logic [1:0]    act_cnt_reg;
  logic [3:0]    act_code_reg;

  logic          slot_end;
  logic [2:0]    col_act;
  logic [3:0]    col_code [3];
  logic [1:0]    row_hits;
  logic [3:0]    row_code;
  logic [2:0]    hit_total;
  logic [1:0]    act_cnt_next;
  logic [3:0]    act_code_next;

  assign slot_end = (div_reg == DIV_LAST);
  assign col_act  = ~col_i;
  assign row_o    = ~(4'b0001 << row_reg);

  for (genvar gi = 0; gi < 3; gi++) begin : g_col_code
    assign col_code[gi] = key_map(row_reg, 2'(gi));
  end

  // Hit count saturates at 2: anything beyond one key is ghosting anyway.
  always_comb begin
    row_hits = 2'd0;
    row_code = 4'd0;
    for (int c = 0; c < 3; c++) begin
      if (col_act[c]) begin
        row_hits = row_hits + 2'd1;
        row_code = col_code[c];
      end
    end
    hit_total     = {1'b0, act_cnt_reg} + {1'b0, row_hits};
    act_cnt_next  = (hit_total >= 3'd2) ? 2'd2 : hit_total[1:0];
    act_code_next = (act_cnt_reg == 2'd0) ? row_code : act_code_reg;
  end

  assign frame_done = slot_end && (row_reg == 2'd3);
  assign frame_code = act_code_next;

  always_comb begin
    case (act_cnt_next)
      2'd0:    frame_kind = FRAME_EMPTY;
      2'd1:    frame_kind = FRAME_SINGLE;
      default: frame_kind = FRAME_MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_reg      <= '0;
      row_reg      <= 2'd0;
      act_cnt_reg  <= 2'd0;
      act_code_reg <= 4'd0;
    end else if (slot_end) begin
      div_reg <= '0;
      row_reg <= row_reg + 2'd1;
      if (row_reg == 2'd3) begin
        act_cnt_reg  <= 2'd0;
        act_code_reg <= 4'd0;
      end else begin
        act_cnt_reg  <= act_cnt_next;
        act_code_reg <= act_code_next;
      end
    end else begin
      div_reg <= div_reg + DW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad front end: debounces frame results and hands one code per press
// to the consumer. Define KEYPAD_AUTOREPEAT_EN to re-emit held keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [3:0]        row_o,
  input  logic [2:0]        col_i,
  keypad_scanner_if.master  key_if
);

  localparam int            CW      = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_FRAMES - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic        frame_done;
  frame_kind_e frame_kind;
  logic [3:0]  frame_code;
  logic        is_single;

  key_state_e  state_reg, state_next;
  logic [3:0]  cand_reg, cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] rel_cnt_reg, rel_cnt_next;
  logic        confirm;

  logic [3:0]  code_reg;
  logic        valid_reg;
  logic        overrun_reg;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
  logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
`endif

  keypad_frame_collect #(
    .SCAN_DIV (SCAN_DIV)
  ) u_collect (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_o      (row_o),
    .col_i      (col_i),
    .frame_done (frame_done),
    .frame_kind (frame_kind),
    .frame_code (frame_code)
  );

  // Ghosted (MULTI) frames count as empty everywhere below.
  assign is_single = (frame_kind == FRAME_SINGLE);

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    rel_cnt_next = rel_cnt_reg;
    confirm      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_next = rep_cnt_reg;
`endif
    if (frame_done) begin
      case (state_reg)
        ST_IDLE: begin
          if (is_single) begin
            cand_next    = frame_code;
            cnt_next     = CW'(1);
            rel_cnt_next = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_next = '0;
`endif
            if (DEBOUNCE_FRAMES == 1) begin
              confirm    = 1'b1;
              state_next = ST_PRESSED;
            end else begin
              state_next = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (is_single && frame_code == cand_reg) begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == DB_LAST) begin
              confirm      = 1'b1;
              state_next   = ST_PRESSED;
              rel_cnt_next = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_next = '0;
`endif
            end
          end else if (is_single) begin
            cand_next = frame_code;
            cnt_next  = CW'(1);
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end
        ST_PRESSED: begin
          if (is_single) begin
            rel_cnt_next = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (frame_code == cand_reg) begin
              if (rep_cnt_reg == REP_LAST) begin
                confirm      = 1'b1;
                rep_cnt_next = '0;
              end else begin
                rep_cnt_next = rep_cnt_reg + RW'(1);
              end
            end else begin
              rep_cnt_next = '0;
            end
`endif
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_next = '0;
`endif
            if (rel_cnt_reg == DB_LAST) begin
              state_next   = ST_IDLE;
              rel_cnt_next = '0;
              cnt_next     = '0;
            end else begin
              rel_cnt_next = rel_cnt_reg + CW'(1);
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cand_reg    <= 4'd0;
      cnt_reg     <= '0;
      rel_cnt_reg <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      cnt_reg     <= cnt_next;
      rel_cnt_reg <= rel_cnt_next;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg <= rep_cnt_next;
`endif
    end
  end

  // Single-entry buffer; a handshake in the confirm cycle frees room for the new key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_reg    <= 4'd0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (confirm) begin
        if (!valid_reg || key_if.key_ready) begin
          code_reg  <= cand_next;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && key_if.key_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign key_if.key_code  = code_reg;
  assign key_if.key_valid = valid_reg;
  assign key_if.overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// (16-cycle frames); a simulated keypad matrix answers the row drive.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row_o;
  logic [2:0]  col_i;
  logic [11:0] keys = 12'd0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3),
    .REPEAT_FRAMES   (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .row_o  (row_o),
    .col_i  (col_i),
    .key_if (kif.master)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_i = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (!row_o[r]) col_i = col_i & ~keys[r*3 +: 3];
    end
  end

  function automatic logic [11:0] kbit(input int r, input int c);
    logic [11:0] one;
    one = 12'd1;
    return one << (r * 3 + c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    kif.key_ready = 1'b0;
    keys = 12'd0;
    do_reset();
    checks++;
    if (row_o !== 4'b1110) begin failures++; $display("FAIL reset_row got=%b exp=1110", row_o); end
    checks++;
    if (kif.key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%h exp=0", kif.key_code); end
    checks++;
    if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", kif.key_valid); end
    checks++;
    if (kif.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", kif.overrun); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single_press();
    int n_valid, first_valid, n_ovr;
    logic [3:0] code_seen, one_hot, exp_row;
    n_valid = 0; first_valid = -1; n_ovr = 0; code_seen = 4'hf; one_hot = 4'b0001;
    do_reset();
    kif.key_ready = 1'b1;
    keys = kbit(1, 1);
    while (cyc < 320) begin
      if (cyc < 16) begin
        exp_row = ~(one_hot << (cyc / 4));
        checks++;
        if (row_o !== exp_row) begin failures++; $display("FAIL row_scan cyc=%0d got=%b exp=%b", cyc, row_o, exp_row); end
      end
      if (kif.key_valid) begin
        if (n_valid == 0) begin first_valid = cyc; code_seen = kif.key_code; end
        n_valid++;
      end
      if (kif.overrun) n_ovr++;
      tick();
    end
    keys = 12'd0;
    while (cyc < 400) begin
      if (kif.key_valid) n_valid++;
      if (kif.overrun) n_ovr++;
      tick();
    end
    checks++;
    if (n_valid != 1) begin failures++; $display("FAIL press5_count got=%0d exp=1", n_valid); end
    checks++;
    if (first_valid != 48) begin failures++; $display("FAIL press5_latency got=%0d exp=48", first_valid); end
    checks++;
    if (code_seen !== 4'd5) begin failures++; $display("FAIL press5_code got=%h exp=5", code_seen); end
    checks++;
    if (n_ovr != 0) begin failures++; $display("FAIL press5_overrun got=%0d exp=0", n_ovr); end
    $display("test_single_press key=5 valid_cycle=%0d pulses=%0d", first_valid, n_valid);
  endtask

  task automatic test_bounce();
    int n_valid, first_valid;
    logic [3:0] code_seen;
    n_valid = 0; first_valid = -1; code_seen = 4'hf;
    do_reset();
    kif.key_ready = 1'b1;
    while (cyc < 128) begin
      keys = ((cyc / 16) == 1) ? 12'd0 : kbit(0, 2);
      if (kif.key_valid) begin
        if (n_valid == 0) begin first_valid = cyc; code_seen = kif.key_code; end
        n_valid++;
      end
      tick();
    end
    keys = 12'd0;
    checks++;
    if (n_valid != 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", n_valid); end
    checks++;
    if (first_valid != 80) begin failures++; $display("FAIL bounce_latency got=%0d exp=80", first_valid); end
    checks++;
    if (code_seen !== 4'd3) begin failures++; $display("FAIL bounce_code got=%h exp=3", code_seen); end
    $display("test_bounce key=3 valid_cycle=%0d pulses=%0d", first_valid, n_valid);
  endtask

  task automatic test_ghost();
    int n_valid, n_ovr;
    n_valid = 0; n_ovr = 0;
    do_reset();
    kif.key_ready = 1'b1;
    keys = kbit(0, 0) | kbit(2, 1);
    while (cyc < 160) begin
      if (kif.key_valid) n_valid++;
      if (kif.overrun) n_ovr++;
      tick();
    end
    keys = 12'd0;
    checks++;
    if (n_valid != 0) begin failures++; $display("FAIL ghost_valid got=%0d exp=0", n_valid); end
    checks++;
    if (n_ovr != 0) begin failures++; $display("FAIL ghost_overrun got=%0d exp=0", n_ovr); end
    $display("test_ghost keys=1+8 valid=%0d overrun=%0d", n_valid, n_ovr);
  endtask

  task automatic test_overrun();
    int first_valid, n_ovr, ovr_cyc, bad_code;
    first_valid = -1; n_ovr = 0; ovr_cyc = -1; bad_code = 0;
    do_reset();
    kif.key_ready = 1'b0;
    while (cyc < 160) begin
      if (cyc / 16 < 3)      keys = kbit(3, 0);
      else if (cyc / 16 < 6) keys = 12'd0;
      else                   keys = kbit(3, 2);
      if (kif.key_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (kif.key_code !== KEY_STAR) bad_code++;
      end
      if (kif.overrun) begin n_ovr++; ovr_cyc = cyc; end
      tick();
    end
    checks++;
    if (first_valid != 48) begin failures++; $display("FAIL ovr_first_valid got=%0d exp=48", first_valid); end
    checks++;
    if (bad_code != 0) begin failures++; $display("FAIL ovr_code_stable got=%0d exp=0", bad_code); end
    checks++;
    if (n_ovr != 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", n_ovr); end
    checks++;
    if (ovr_cyc != 144) begin failures++; $display("FAIL ovr_cycle got=%0d exp=144", ovr_cyc); end
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== KEY_STAR) begin
      failures++; $display("FAIL ovr_held got=%b/%h exp=1/a", kif.key_valid, kif.key_code);
    end
    keys = 12'd0;
    kif.key_ready = 1'b1;
    tick();
    kif.key_ready = 1'b0;
    checks++;
    if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL ovr_handshake_drop got=%b exp=0", kif.key_valid); end
    checks++;
    if (kif.key_code !== KEY_STAR) begin failures++; $display("FAIL ovr_code_kept got=%h exp=a", kif.key_code); end
    $display("test_overrun star held, overrun at cycle=%0d", ovr_cyc);
  endtask

  task automatic test_back_to_back();
    int n_ovr;
    n_ovr = 0;
    do_reset();
    kif.key_ready = 1'b0;
    while (cyc <= 145) begin
      kif.key_ready = (cyc == 143 || cyc == 144);
      if (cyc / 16 < 3)      keys = kbit(2, 2);
      else if (cyc / 16 < 6) keys = 12'd0;
      else                   keys = kbit(1, 0);
      if (kif.overrun) n_ovr++;
      if (cyc == 143) begin
        checks++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd9) begin
          failures++; $display("FAIL b2b_before got=%b/%h exp=1/9", kif.key_valid, kif.key_code);
        end
      end
      if (cyc == 144) begin
        checks++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd4) begin
          failures++; $display("FAIL b2b_load got=%b/%h exp=1/4", kif.key_valid, kif.key_code);
        end
      end
      if (cyc == 145) begin
        checks++;
        if (kif.key_valid !== 1'b0 || kif.key_code !== 4'd4) begin
          failures++; $display("FAIL b2b_drain got=%b/%h exp=0/4", kif.key_valid, kif.key_code);
        end
      end
      tick();
    end
    kif.key_ready = 1'b0;
    keys = 12'd0;
    checks++;
    if (n_ovr != 0) begin failures++; $display("FAIL b2b_overrun got=%0d exp=0", n_ovr); end
    $display("test_back_to_back key 9 then 4 with same-cycle handshake");
  endtask

  task automatic test_reset_mid();
    int first_valid;
    logic [3:0] code_seen;
    first_valid = -1; code_seen = 4'hf;
    do_reset();
    kif.key_ready = 1'b0;
    while (cyc < 140) begin
      if (cyc / 16 < 3)      keys = kbit(2, 0);
      else if (cyc / 16 < 6) keys = 12'd0;
      else                   keys = kbit(3, 1);
      tick();
    end
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd7) begin
      failures++; $display("FAIL rstmid_pre got=%b/%h exp=1/7", kif.key_valid, kif.key_code);
    end
    do_reset();
    checks++;
    if (kif.key_valid !== 1'b0 || kif.key_code !== 4'd0 || kif.overrun !== 1'b0 || row_o !== 4'b1110) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%h/%b/%b exp=0/0/0/1110", kif.key_valid, kif.key_code, kif.overrun, row_o);
    end
    while (cyc < 64) begin
      if (kif.key_valid && first_valid < 0) begin first_valid = cyc; code_seen = kif.key_code; end
      tick();
    end
    keys = 12'd0;
    checks++;
    if (first_valid != 48) begin failures++; $display("FAIL rstmid_latency got=%0d exp=48", first_valid); end
    checks++;
    if (code_seen !== 4'd0) begin failures++; $display("FAIL rstmid_code got=%h exp=0", code_seen); end
    $display("test_reset_mid key=0 fresh valid_cycle=%0d", first_valid);
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int n_valid;
    int at [3];
    int bad_code;
    n_valid = 0; bad_code = 0;
    at[0] = -1; at[1] = -1; at[2] = -1;
    do_reset();
    kif.key_ready = 1'b1;
    keys = kbit(0, 1);
    while (cyc < 210) begin
      if (kif.key_valid) begin
        if (n_valid < 3) at[n_valid] = cyc;
        if (kif.key_code !== 4'd2) bad_code++;
        n_valid++;
      end
      tick();
    end
    keys = 12'd0;
    checks++;
    if (n_valid != 3) begin failures++; $display("FAIL rep_count got=%0d exp=3", n_valid); end
    checks++;
    if (at[0] != 48 || at[1] != 128 || at[2] != 208) begin
      failures++; $display("FAIL rep_cycles got=%0d,%0d,%0d exp=48,128,208", at[0], at[1], at[2]);
    end
    checks++;
    if (bad_code != 0) begin failures++; $display("FAIL rep_code got=%0d exp=0", bad_code); end
    $display("test_autorepeat key=2 emissions=%0d", n_valid);
  endtask
`endif

  initial begin
    kif.key_ready = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the elevator controller's login path. Drives a 4x3 keypad row by row, debounces the sensed columns, and delivers one 4-bit key code per physical press over a valid/ready handshake. Its consumer is the credential-entry FSM, which takes digits for the 3-digit username and 4-digit password, `*` to start and `#` to terminate.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven; minimum 2.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical frames required to accept a press or release; minimum 1.
- `REPEAT_FRAMES`, default 50: auto-repeat period in frames. Used only with the configuration macro.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `row_o` output 4: row drive, active-low one-hot.
- `col_i` input 3: column sense, active-low. Already synchronized externally.
- `key_code` output 4: `0`–`9` = digits, `4'b1010` = star, `4'b1011` = hash.
- `key_valid` output 1: `key_code` holds a key not yet taken.
- `key_ready` input 1: consumer accepts the key this cycle.
- `overrun` output 1: one-cycle pulse when a confirmed key is dropped.

## Operation
- **Row scan.**
  - A row counter (0–3) and a divider (0..`SCAN_DIV`-1) advance continuously in every state.
  - `row_o` = `~(4'b0001 << row)`.
  - `col_i` is sampled on the last divider cycle of each row slot.
  - A frame is 4 row slots.
- **Key map (row r, column c).**
  - Rows 0–2: code = 3r + c + 1.
  - Row 3: c0 = star (`1010`), c1 = `0`, c2 = hash (`1011`).
- **Frame result.** Exactly one active column across the whole frame gives SINGLE(code). Zero active gives EMPTY. Two or more give MULTI (ghosting), which is treated as EMPTY.
- **FSM.** States are IDLE, DEBOUNCE and PRESSED. It is evaluated once per frame, at frame end.
  - IDLE:
    - SINGLE: latch candidate, count = 1, go to DEBOUNCE. If `DEBOUNCE_FRAMES` = 1, confirm immediately and go to PRESSED.
  - DEBOUNCE:
    - Same code: count + 1. When count reaches `DEBOUNCE_FRAMES`, confirm and go to PRESSED.
    - Different SINGLE: new candidate, count = 1.
    - EMPTY: go to IDLE.
  - PRESSED:
    - Any non-EMPTY frame clears the release counter. A different key seen while pressed is ignored.
    - `DEBOUNCE_FRAMES` consecutive EMPTY frames: go to IDLE.
- **Output buffer.** One entry.
  - On confirm with `key_valid` = 0: load `key_code`, set `key_valid`.
  - On confirm with `key_valid` = 1 and no handshake that cycle: the new key is dropped, `overrun` pulses, and the buffer is unchanged.
  - `key_valid` && `key_ready`: clear `key_valid`. `key_code` keeps its last value.
  - Confirm and handshake in the same cycle: the new key loads and `key_valid` stays 1. No overrun.

## Timing
- **Reset values:** `row_o` = `4'b1110`; `key_code` = 0; `key_valid` = 0; `overrun` = 0. FSM goes to IDLE and all counters to 0.
- **Reset mid-operation:** a pending key and any debounce progress are discarded.
- **Frame length:** 4*`SCAN_DIV` cycles.
- **Press latency:** `key_valid` rises 1 cycle after the frame end of the `DEBOUNCE_FRAMES`-th consecutive matching frame.
- **Handshake:**
  - `key_code` is stable while `key_valid` = 1.
  - `key_valid` may remain high indefinitely.
  - `key_valid` drops the cycle after the handshake cycle.
- **Release:** release detection adds no output activity.
- **Wrap-around:** the row counter wraps 3→0 and the divider wraps to 0; counts saturate at their targets.
- **Widths:** every counter is `$clog2` of its maximum + 1.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, each SINGLE frame with the confirmed code increments a repeat counter.
  - After `REPEAT_FRAMES` such frames the code is re-confirmed through the output buffer (same overrun rules) and the counter restarts.
  - Any other frame result clears the counter.
- `KEYPAD_AUTOREPEAT_EN` undefined: exactly one confirm per press. `REPEAT_FRAMES` is ignored and the repeat counter is not built.

## Structure
- **Shared package `keypad_pkg`:**
  - Key code constants: `KEY_STAR` = `4'b1010`, `KEY_HASH` = `4'b1011`, digits `0`–`9`.
  - FSM state encoding.
  - Frame-result encoding (EMPTY/SINGLE/MULTI).
- **Sub-module `keypad_frame_collect`:**
  - Owns the row drive, the divider, and the per-frame column accumulation.
  - Outputs `frame_done`, `frame_kind` and `frame_code` to the FSM.

## Test plan
Use `SCAN_DIV`=4 and `DEBOUNCE_FRAMES`=3 (frame = 16 cycles).
- Hold row 1/col 1 for 20 frames with `key_ready`=1 → exactly one `key_valid` pulse with `key_code`=5, 1 cycle after frame 3 end; `row_o` cycles `1110`,`1101`,`1011`,`0111`.
- Bounce row 0/col 2 (on, off, on) then hold steady → a single `key_code`=3, confirmed 3 frames after the last bounce.
- Press row 0/col 0 and row 2/col 1 together for 10 frames → no `key_valid`, no `overrun`.
- `key_ready`=0; press star, release, press hash → `key_code`=`1010` held with `key_valid`=1 and one `overrun` pulse. Then `key_ready`=1 for one cycle → `key_valid`=0 the next cycle.
- Assert `rst_n`=0 for 1 cycle mid-DEBOUNCE on key `0` → all outputs at reset values, no later emission without 3 fresh matching frames.
- With `KEYPAD_AUTOREPEAT_EN` and `REPEAT_FRAMES`=5: hold key 2 for 13 frames → 3 emissions, at frames 3, 8 and 13.
